// File: rtl/cmd_reader_pkg.sv
// Shared definitions for the command reader: FSM encodings, command ids and
// the control characters that steer line editing.
package cmd_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_RESULT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LED  = 2'd1;
  localparam logic [1:0] CMD_HELP = 2'd2;
  localparam logic [1:0] CMD_PING = 2'd3;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/cmd_reader_rx.sv
// UART 8N1 receiver: two-flop synchroniser, glitch-rejecting start detect,
// centre sampling, registered byte strobe and frame-error pulse.
module rx
  import cmd_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_in,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]       warm_q, warm_d;
  rx_state_e        rstate_q, rstate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             strobe_q, strobe_d, ferr_q, ferr_d;
  logic             fall;

  // Edges only count once prev/sync2 both hold real line samples after reset,
  // so a line that was already low during reset cannot fake a start bit.
  assign fall = (warm_q == 2'd3) && prev_q && !sync2_q;

  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 1'b1;
    rstate_d = rstate_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    case (rstate_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) rstate_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d    = '0;
          bit_d    = '0;
          rstate_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) rstate_d = RX_STOP;
          else               bit_d    = bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d    = '0;
          rstate_d = RX_IDLE;
          if (sync2_q) begin
            strobe_d = 1'b1;
            data_d   = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      warm_q   <= '0;
      rstate_q <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      warm_q   <= warm_d;
      rstate_q <= rstate_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    data_q  <= data_d;
  end

  assign data_in   = data_q;
  assign rx_strobe = strobe_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/cmd_reader.sv
// Line-editing command reader: collects UART characters into a buffer and
// reports a recognised command id (or an error) when a line terminator arrives.
module cmd_reader
  import cmd_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int BUF_LEN      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  output logic       cmd_valid,
  output logic       cmd_error,
  output logic [1:0] cmd_id,
  output logic [1:0] cmd_state,
  output logic       frame_err
);

  localparam int PTR_W = $clog2(BUF_LEN + 1);
  localparam int IDX_W = $clog2(BUF_LEN);

  logic [7:0] rx_data;
  logic       rx_strobe;

  rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_in   (rx_data),
    .rx_strobe (rx_strobe),
    .frame_err (frame_err)
  );

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [BUF_LEN-1:0][7:0]  buf_q, buf_d;
  logic                     cmd_valid_q, cmd_valid_d, cmd_error_q, cmd_error_d;
  logic [1:0]               cmd_id_q, cmd_id_d, match_id;

  function automatic logic [1:0] match_cmd(input logic [BUF_LEN-1:0][7:0] b,
                                           input logic [PTR_W-1:0] n);
    if (n == PTR_W'(3) && b[0] == "l" && b[1] == "e" && b[2] == "d")
      return CMD_LED;
    if (n == PTR_W'(4) && b[0] == "h" && b[1] == "e" && b[2] == "l" && b[3] == "p")
      return CMD_HELP;
    if (n == PTR_W'(4) && b[0] == "p" && b[1] == "i" && b[2] == "n" && b[3] == "g")
      return CMD_PING;
    return CMD_NONE;
  endfunction

  assign match_id = match_cmd(buf_q, ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    buf_d       = buf_q;
    cmd_valid_d = 1'b0;
    cmd_error_d = 1'b0;
    cmd_id_d    = cmd_id_q;
    // Dropping enable wins over everything, including a terminator in flight.
    if (!enable) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ptr_d   = '0;
          state_d = ST_READ;
        end
        ST_READ: begin
          if (rx_strobe) begin
            if (is_term(rx_data)) begin
              if (ptr_q != '0) begin
                state_d     = ST_RESULT;
                cmd_id_d    = match_id;
                cmd_valid_d = (match_id != CMD_NONE);
                cmd_error_d = (match_id == CMD_NONE);
              end
            end else if (is_printable(rx_data)) begin
              if (ptr_q == PTR_W'(BUF_LEN)) begin
                state_d = ST_DISCARD;
              end else begin
                buf_d[ptr_q[IDX_W-1:0]] = rx_data;
                ptr_d = ptr_q + 1'b1;
              end
            end else if (rx_data == CH_BS && ptr_q != '0) begin
              ptr_d = ptr_q - 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (rx_strobe && is_term(rx_data)) begin
            state_d     = ST_RESULT;
            cmd_id_d    = CMD_NONE;
            cmd_error_d = 1'b1;
          end
        end
        ST_RESULT: begin
          ptr_d   = '0;
          state_d = ST_READ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_error_q <= 1'b0;
      cmd_id_q    <= CMD_NONE;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_error_q <= cmd_error_d;
      cmd_id_q    <= cmd_id_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_error = cmd_error_q;
  assign cmd_id    = cmd_id_q;
  assign cmd_state = state_q;

endmodule
